// File: rtl/dtu_tx_pkg.sv
// Shared types and constants for the DTU transmit scheduler: state encoding,
// fill/reset patterns and the trailer word layout.
package dtu_tx_pkg;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_DATA    = 3'd2,
        ST_TRAILER = 3'd3,
        ST_RST     = 3'd4
    } tx_state_e;

    localparam logic [31:0] IDLE_PAT     = 32'hEAEA_EAEA;
    localparam logic [31:0] ATM_PAT      = 32'h5A5A_5A5A;
    localparam logic [31:0] RST_WORD     = 32'h3400_0000;
    localparam logic [3:0]  TRAILER_CODE = 4'b1101;
    localparam logic [7:0]  CRC8_POLY    = 8'h07;

    localparam int TRL_CODE_MSB = 31;
    localparam int TRL_CODE_LSB = 28;
    localparam int TRL_FCNT_MSB = 27;
    localparam int TRL_FCNT_LSB = 20;
    localparam int TRL_WCNT_MSB = 19;
    localparam int TRL_WCNT_LSB = 12;
    localparam int TRL_RSVD_MSB = 11;
    localparam int TRL_RSVD_LSB = 8;
    localparam int TRL_CRC_MSB  = 7;
    localparam int TRL_CRC_LSB  = 0;

    function automatic logic [31:0] build_trailer(input logic [7:0] fcnt,
                                                  input logic [7:0] wcnt,
                                                  input logic [7:0] crc);
        logic [31:0] t;
        t = 32'h0000_0000;
        t[TRL_CODE_MSB:TRL_CODE_LSB] = TRAILER_CODE;
        t[TRL_FCNT_MSB:TRL_FCNT_LSB] = fcnt;
        t[TRL_WCNT_MSB:TRL_WCNT_LSB] = wcnt;
        t[TRL_RSVD_MSB:TRL_RSVD_LSB] = 4'h0;
        t[TRL_CRC_MSB:TRL_CRC_LSB]   = crc;
        return t;
    endfunction

endpackage

// File: rtl/dtu_crc8.sv
// Combinational CRC-8 (poly 0x07, MSB first) update of a running value
// with one 32-bit word.
module dtu_crc8
    import dtu_tx_pkg::*;
(
    input  logic [7:0]  crc_in,
    input  logic [31:0] data,
    output logic [7:0]  crc_out
);

    function automatic logic [7:0] crc8_word(input logic [7:0] c, input logic [31:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            if ((r[7] ^ d[i]) == 1'b1) begin
                r = {r[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                r = {r[6:0], 1'b0};
            end
        end
        return r;
    endfunction

    // Fold the whole word into the running CRC.
    always_comb begin
        crc_out = crc8_word(crc_in, data);
    end

endmodule

// File: rtl/dtu_tx_scheduler.sv
// Slot-based word scheduler for the DTU serial link: sync fill, framed data
// with trailers, link reset words and ATM test pattern.
// Optional trailer CRC is enabled with `define DTU_TRAILER_CRC_EN.
module dtu_tx_scheduler
    import dtu_tx_pkg::*;
#(
    parameter int SYNC_WORDS  = 16,
    parameter int FRAME_WORDS = 50
) (
    input  logic        clk_160,
    input  logic        rst,
    input  logic [31:0] word_data,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        calib_busy,
    input  logic        test_enable,
    input  logic        sync_rst_req,
    output logic [31:0] tx_word,
    output logic        ser_load,
    output logic [7:0]  frame_cnt,
    output logic        aligned
);

    localparam int SYNC_W = $clog2(SYNC_WORDS + 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAME_WORDS);

    logic [1:0]        phase_r;
    tx_state_e         state_r, state_next_s;
    logic [SYNC_W-1:0] sync_cnt_r, sync_cnt_next_s;
    logic [7:0]        word_cnt_r, word_cnt_next_s;
    logic [7:0]        frame_cnt_r, frame_cnt_next_s;
    logic              rst_pending_r, rst_pending_next_s;
    logic              pend_clear_s;
    logic [31:0]       tx_word_r, tx_word_next_s;
    logic              ser_load_r;
    logic              aligned_r;
    logic              slot_tick_s;
    logic              word_ready_s;
    logic              accept_s;
    logic [7:0]        data_wcnt_s;
    logic [7:0]        crc_field_s;

    assign slot_tick_s  = (phase_r == 2'd3);
    assign word_ready_s = slot_tick_s && ((state_r == ST_IDLE) || (state_r == ST_DATA))
                          && !calib_busy && !test_enable && !rst_pending_r;
    assign accept_s     = word_ready_s && word_valid;
    assign data_wcnt_s  = (state_r == ST_IDLE) ? 8'd1 : (word_cnt_r + 8'd1);

`ifdef DTU_TRAILER_CRC_EN
    logic [7:0] crc_r, crc_next_s, crc_upd_s;

    dtu_crc8 u_crc8 (
        .crc_in  (crc_r),
        .data    (word_data),
        .crc_out (crc_upd_s)
    );

    // Running CRC over accepted words; cleared once a trailer or reset word goes out.
    always_comb begin
        crc_next_s = crc_r;
        if (slot_tick_s && !test_enable && ((state_r == ST_TRAILER) || (state_r == ST_RST))) begin
            crc_next_s = 8'h00;
        end else if (accept_s) begin
            crc_next_s = crc_upd_s;
        end else begin
            crc_next_s = crc_r;
        end
    end

    // CRC register.
    always_ff @(posedge clk_160 or posedge rst) begin
        if (rst) begin
            crc_r <= 8'h00;
        end else begin
            crc_r <= crc_next_s;
        end
    end

    assign crc_field_s = crc_r;
`else
    assign crc_field_s = 8'h00;
`endif

    // Per-slot word selection and state transitions; nothing moves between slots.
    always_comb begin
        state_next_s     = state_r;
        sync_cnt_next_s  = sync_cnt_r;
        word_cnt_next_s  = word_cnt_r;
        frame_cnt_next_s = frame_cnt_r;
        tx_word_next_s   = tx_word_r;
        pend_clear_s     = 1'b0;
        if (!slot_tick_s) begin
            state_next_s = state_r;
        end else if (test_enable) begin
            // Test pattern freezes the frame state but lets sync counting run on.
            tx_word_next_s = ATM_PAT;
            if ((state_r == ST_SYNC) && (sync_cnt_r != SYNC_LAST)) begin
                sync_cnt_next_s = sync_cnt_r + SYNC_W'(1);
            end else begin
                sync_cnt_next_s = sync_cnt_r;
            end
        end else begin
            case (state_r)
                ST_SYNC: begin
                    tx_word_next_s = IDLE_PAT;
                    if (sync_cnt_r == SYNC_LAST) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        sync_cnt_next_s = sync_cnt_r + SYNC_W'(1);
                    end
                end
                ST_IDLE, ST_DATA: begin
                    if (rst_pending_r) begin
                        tx_word_next_s = IDLE_PAT;
                        state_next_s   = ST_RST;
                    end else if (accept_s) begin
                        tx_word_next_s  = word_data;
                        word_cnt_next_s = data_wcnt_s;
                        state_next_s    = (data_wcnt_s == FRAME_LAST) ? ST_TRAILER : ST_DATA;
                    end else begin
                        tx_word_next_s = IDLE_PAT;
                    end
                end
                ST_TRAILER: begin
                    tx_word_next_s   = build_trailer(frame_cnt_r, word_cnt_r, crc_field_s);
                    frame_cnt_next_s = frame_cnt_r + 8'd1;
                    word_cnt_next_s  = 8'd0;
                    state_next_s     = ST_IDLE;
                end
                ST_RST: begin
                    tx_word_next_s   = RST_WORD;
                    frame_cnt_next_s = 8'd0;
                    word_cnt_next_s  = 8'd0;
                    pend_clear_s     = 1'b1;
                    state_next_s     = ST_IDLE;
                end
                default: begin
                    tx_word_next_s = IDLE_PAT;
                    state_next_s   = ST_SYNC;
                end
            endcase
        end
    end

    // Reset requests merge while pending; a request arriving as RST is emitted stays armed.
    always_comb begin
        if (sync_rst_req) begin
            rst_pending_next_s = 1'b1;
        end else if (pend_clear_s) begin
            rst_pending_next_s = 1'b0;
        end else begin
            rst_pending_next_s = rst_pending_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_160 or posedge rst) begin
        if (rst) begin
            phase_r       <= 2'd0;
            state_r       <= ST_SYNC;
            sync_cnt_r    <= '0;
            word_cnt_r    <= 8'd0;
            frame_cnt_r   <= 8'd0;
            rst_pending_r <= 1'b0;
            tx_word_r     <= IDLE_PAT;
            ser_load_r    <= 1'b0;
            aligned_r     <= 1'b0;
        end else begin
            phase_r       <= phase_r + 2'd1;
            state_r       <= state_next_s;
            sync_cnt_r    <= sync_cnt_next_s;
            word_cnt_r    <= word_cnt_next_s;
            frame_cnt_r   <= frame_cnt_next_s;
            rst_pending_r <= rst_pending_next_s;
            tx_word_r     <= tx_word_next_s;
            ser_load_r    <= slot_tick_s;
            aligned_r     <= (state_next_s != ST_SYNC);
        end
    end

    assign word_ready = word_ready_s;
    assign tx_word    = tx_word_r;
    assign ser_load   = ser_load_r;
    assign frame_cnt  = frame_cnt_r;
    assign aligned    = aligned_r;

endmodule

// File: tb/tb_dtu_tx_scheduler.sv
// Scoreboard bench for dtu_tx_scheduler: a slot-level reference model queues
// the expected word per slot, a monitor pops on every ser_load strobe.
module tb_dtu_tx_scheduler;

    localparam int SW = 16;
    localparam int FW = 4;
    localparam logic [31:0] EXP_IDLE = 32'hEAEA_EAEA;
    localparam logic [31:0] EXP_ATM  = 32'h5A5A_5A5A;
    localparam logic [31:0] EXP_RST  = 32'h3400_0000;

    localparam int M_SYNC = 0;
    localparam int M_IDLE = 1;
    localparam int M_DATA = 2;
    localparam int M_TRL  = 3;
    localparam int M_RST  = 4;

    logic        clk_160 = 1'b0;
    logic        rst;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        calib_busy;
    logic        test_enable;
    logic        sync_rst_req;
    logic [31:0] tx_word;
    logic        ser_load;
    logic [7:0]  frame_cnt;
    logic        aligned;

    dtu_tx_scheduler #(.SYNC_WORDS(SW), .FRAME_WORDS(FW)) dut (
        .clk_160      (clk_160),
        .rst          (rst),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .calib_busy   (calib_busy),
        .test_enable  (test_enable),
        .sync_rst_req (sync_rst_req),
        .tx_word      (tx_word),
        .ser_load     (ser_load),
        .frame_cnt    (frame_cnt),
        .aligned      (aligned)
    );

    always #5 clk_160 = ~clk_160;

    typedef struct packed {
        logic [31:0] word;
        logic        algn;
        logic [7:0]  fcnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_mode;
    int          m_sync_seen;
    bit          m_pend;
    int          m_frames;
    int          m_phase;
    logic [31:0] m_frame[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] frame_crc();
        logic [7:0] c;
        c = 8'h00;
`ifdef DTU_TRAILER_CRC_EN
        foreach (m_frame[k]) begin
            for (int b = 31; b >= 0; b--) begin
                logic fb;
                fb = c[7] ^ m_frame[k][b];
                c = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
`endif
        return c;
    endfunction

    function automatic bit exp_ready();
        return (m_phase == 3) && (m_mode == M_IDLE || m_mode == M_DATA)
               && !calib_busy && !test_enable && !m_pend;
    endfunction

    task automatic model_reset();
        m_mode = M_SYNC;
        m_sync_seen = 0;
        m_pend = 0;
        m_frames = 0;
        m_phase = 0;
        m_frame.delete();
    endtask

    // Called at each rising edge with the inputs that were presented during the cycle.
    task automatic model_edge();
        logic [31:0] w;
        bit          acc;
        acc = exp_ready() && word_valid;
        if (m_phase == 3) begin
            w = EXP_IDLE;
            if (test_enable) begin
                w = EXP_ATM;
                if (m_mode == M_SYNC) m_sync_seen++;
            end else begin
                case (m_mode)
                    M_SYNC: begin
                        m_sync_seen++;
                        if (m_sync_seen >= SW) m_mode = M_IDLE;
                    end
                    M_IDLE, M_DATA: begin
                        if (m_pend) begin
                            m_frame.delete();
                            m_mode = M_RST;
                        end else if (acc) begin
                            m_frame.push_back(word_data);
                            w = word_data;
                            m_mode = (m_frame.size() == FW) ? M_TRL : M_DATA;
                        end
                    end
                    M_TRL: begin
                        w = {4'hD, 8'(m_frames), 8'(m_frame.size()), 4'h0, frame_crc()};
                        m_frames = (m_frames + 1) % 256;
                        m_frame.delete();
                        m_mode = M_IDLE;
                    end
                    M_RST: begin
                        w = EXP_RST;
                        m_frames = 0;
                        m_frame.delete();
                        m_pend = 0;
                        m_mode = M_IDLE;
                    end
                    default: ;
                endcase
            end
            sb_q.push_back('{word: w, algn: (m_mode != M_SYNC), fcnt: 8'(m_frames)});
        end
        if (sync_rst_req) m_pend = 1;
        m_phase = (m_phase + 1) % 4;
    endtask

    // Entered just after a falling edge; leaves just after the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] d, input bit c, input bit t, input bit r);
        word_valid   = v;
        word_data    = d;
        calib_busy   = c;
        test_enable  = t;
        sync_rst_req = r;
        #1;
        check("word_ready", 32'(word_ready), 32'(exp_ready()));
        check("ser_load_missing", 32'(sb_q.size()), 32'd0);
        if (sb_q.size() != 0) sb_q.delete();
        @(posedge clk_160);
        model_edge();
        @(negedge clk_160);
    endtask

    task automatic do_reset();
        #1;
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        rst = 1'b1;
        word_valid = 1'b0;
        word_data = 32'h0;
        calib_busy = 1'b0;
        test_enable = 1'b0;
        sync_rst_req = 1'b0;
        model_reset();
        sb_q.delete();
        #1;
        check("rst_tx_word", tx_word, EXP_IDLE);
        check("rst_ser_load", 32'(ser_load), 32'd0);
        check("rst_aligned", 32'(aligned), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_word_ready", 32'(word_ready), 32'd0);
        repeat (2) @(posedge clk_160);
        @(negedge clk_160);
        rst = 1'b0;
    endtask

    // Monitor: every ser_load strobe consumes one expected slot word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_160);
            if (rst === 1'b0 && ser_load === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ser_load_extra: got strobe with word %08h expected no strobe", tx_word);
                end else begin
                    e = sb_q.pop_front();
                    check("tx_word", tx_word, e.word);
                    check("aligned", 32'(aligned), 32'(e.algn));
                    check("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
                end
            end
        end
    end

    initial begin
        bit t_on;
        rst = 1'b1;
        word_valid = 1'b0;
        word_data = 32'h0;
        calib_busy = 1'b0;
        test_enable = 1'b0;
        sync_rst_req = 1'b0;
        model_reset();
        @(negedge clk_160);
        do_reset();

        // Sync fill then idle fill.
        repeat (SW * 4 + 8) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // One full frame of a fixed word, then its trailer.
        repeat (FW * 4) cycle(1'b1, 32'h2800_A00B, 1'b0, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset request after two words aborts the frame.
        repeat (8) cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (11) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (FW * 4 + 8) cycle(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);

        // Test mode in the middle of a frame, then resume.
        repeat (8) cycle(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        repeat (16) cycle(1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);
        repeat (16) cycle(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);

        // Calibration blocks acceptance with a word waiting.
        repeat (16) cycle(1'b1, 32'h7777_0000, 1'b1, 1'b0, 1'b0);
        repeat (8) cycle(1'b1, 32'h7777_0000, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with two mid-run resets.
        t_on = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 1500 || i == 2900) do_reset();
            if (t_on) begin
                if ($urandom_range(0, 9) == 0) t_on = 1'b0;
            end else begin
                if ($urandom_range(0, 49) == 0) t_on = 1'b1;
            end
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
                  t_on, $urandom_range(0, 149) == 0);
        end

        // Frame counter wrap: 258 back-to-back frames.
        do_reset();
        repeat (SW * 4 + 8) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 258 * (FW + 1) * 4; i++) begin
            cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        end
        repeat (12) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("frame_cnt_final", 32'(frame_cnt), 32'(m_frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
